// File: rtl/multicast_fork_pkg.sv
// Shared types for the multicast fork: the three-state controller encoding.
package multicast_fork_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FORK = 2'd1,
    ERR  = 2'd2
  } fork_state_e;

endpackage

// File: rtl/multicast_fork.sv
// Multicast fork: registers one decoded request and replays it to every selected
// port; requests matching no port are diverted to the error port instead.
module multicast_fork
  import multicast_fork_pkg::*;
#(
  parameter int unsigned NoOutputs = 32'd2,
  parameter type         addr_t    = logic,
  parameter type         payload_t = logic
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [NoOutputs-1:0]  select_i,
  input  addr_t [NoOutputs-1:0] addr_i,
  input  addr_t [NoOutputs-1:0] mask_i,
  input  payload_t              payload_i,
  output logic [NoOutputs-1:0]  valid_o,
  input  logic [NoOutputs-1:0]  ready_i,
  output addr_t [NoOutputs-1:0] addr_o,
  output addr_t [NoOutputs-1:0] mask_o,
  output payload_t              payload_o,
  output logic                  err_valid_o,
  input  logic                  err_ready_i
);

  fork_state_e           state_q, state_d;
  logic [NoOutputs-1:0]  pending_q, pending_d;
  addr_t [NoOutputs-1:0] addr_q, addr_d, mask_q, mask_d;
  payload_t              payload_q, payload_d;
  logic                  last_hs;

  always_comb begin
    valid_o     = '0;
    err_valid_o = 1'b0;
    ready_o     = 1'b0;
    last_hs     = 1'b0;
    state_d     = state_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    payload_d   = payload_q;

    case (state_q)
      FORK: begin
        valid_o   = pending_q;
        pending_d = pending_q & ~ready_i;
        last_hs   = (pending_d == '0);
      end
      ERR: begin
        err_valid_o = 1'b1;
        last_hs     = err_ready_i;
      end
      default: ready_o = 1'b1;
    endcase

    // Draining the register frees it in the same cycle, so a waiting request
    // can be captured without a bubble.
    if (last_hs) begin
      ready_o   = 1'b1;
      state_d   = IDLE;
      pending_d = '0;
      addr_d    = '0;
      mask_d    = '0;
      payload_d = '0;
    end

    if (valid_i && ready_o) begin
      pending_d = select_i;
      addr_d    = addr_i;
      mask_d    = mask_i;
      payload_d = payload_i;
      state_d   = (select_i != '0) ? FORK : ERR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      payload_q <= payload_d;
    end
  end

  // Held data is zeroed whenever the register empties, so no output gating needed.
  assign addr_o    = addr_q;
  assign mask_o    = mask_q;
  assign payload_o = payload_q;

`ifndef COMMON_CELLS_ASSERTS_OFF
  a_no_outputs : assert property (@(posedge clk_i) NoOutputs > 0);

  a_payload_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|(valid_o & ~ready_i)) |=> $stable(payload_o));

  for (genvar i = 0; i < NoOutputs; i++) begin : g_asrt
    a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o[i] && !ready_i[i]) |=> valid_o[i]);
  end
`endif

endmodule
